// File: rtl/xbus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbus_arb_pkg
// Description : Shared encodings and defaults for the xbus master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package xbus_arb_pkg;

  localparam int unsigned NM_DEF    = 4;
  localparam int unsigned AW_DEF    = 22;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned TMO_W_DEF = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_DONE = ST_DONE
  } arb_state_e;

  localparam int unsigned MST_CPU  = 0;
  localparam int unsigned MST_DISK = 1;
  localparam int unsigned MST_SPY  = 2;
  localparam int unsigned MST_AUX  = 3;

endpackage
`default_nettype wire

// File: rtl/xbus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : xbus_rr_pick
// Description : Combinational round-robin picker, scans from ptr+1 upward.
// Revision    : 1.0 - initial release
// ============================================================================
module xbus_rr_pick
  import xbus_arb_pkg::*;
#(
  parameter int unsigned NM = NM_DEF
) (
  input  logic [NM-1:0]                     req,
  input  logic [((NM > 1) ? $clog2(NM) : 1)-1:0] ptr,
  output logic [NM-1:0]                     pick,
  output logic                              any
);

  localparam int unsigned PW   = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [PW:0] C_NM = (PW+1)'(NM);

  logic [PW:0] w_idx;

  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= int'(NM); i++) begin
      // Wrap ptr+i back into 0..NM-1 without relying on NM being a power of two
      w_idx = {1'b0, ptr} + (PW+1)'(i);
      if (w_idx >= C_NM) w_idx = w_idx - C_NM;
      if (!any && req[w_idx[PW-1:0]]) begin
        pick[w_idx[PW-1:0]] = 1'b1;
        any                 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xbus_arbiter
// Description : Round-robin xbus arbiter with per-master lock and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module xbus_arbiter
  import xbus_arb_pkg::*;
#(
  parameter int unsigned NM    = NM_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned TMO_W = TMO_W_DEF
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic [NM-1:0]     m_req,
  input  logic [NM-1:0]     m_write,
  input  logic [NM-1:0]     m_lock,
  input  logic [NM*AW-1:0]  m_addr,
  input  logic [NM*DW-1:0]  m_wdata,
  output logic [NM-1:0]     m_ack,
  output logic [NM-1:0]     m_load,
  output logic [NM-1:0]     m_err,
  output logic [DW-1:0]     m_rdata,
  output logic              s_req,
  output logic              s_write,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic [DW-1:0]     s_rdata,
  input  logic              s_ack,
  output logic [NM-1:0]     grant,
  output logic [1:0]        arb_state
);

  localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;

  arb_state_e       r_state, w_state_nx;
  logic [NM-1:0]    r_grant, w_grant_nx;
  logic [PW-1:0]    r_ptr, w_ptr_nx;
  logic             r_lock_hold, w_lock_hold_nx;
  logic [PW-1:0]    r_owner, w_owner_nx;
  logic [TMO_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [NM-1:0]    r_ack, w_ack_nx;
  logic [NM-1:0]    r_load, w_load_nx;
  logic [NM-1:0]    r_err, w_err_nx;
  logic [DW-1:0]    r_rdata, w_rdata_nx;

  logic [NM-1:0]    w_pick;
  logic             w_any;
  logic [PW-1:0]    w_gidx;
  logic [NM-1:0]    w_owner_oh;
  logic             w_tmo;

  xbus_rr_pick #(.NM(NM)) u_pick (
    .req  (m_req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < int'(NM); i++) begin
      if (r_grant[i]) w_gidx = PW'(i);
    end
  end

  // Slave side is a plain mux off the grant register; zero when nobody owns the bus
  always_comb begin
    s_write = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < int'(NM); i++) begin
      if (r_grant[i]) begin
        s_write = m_write[i];
        s_addr  = m_addr[i*AW +: AW];
        s_wdata = m_wdata[i*DW +: DW];
      end
    end
  end

  assign s_req      = (r_state == S_REQ);
  assign w_owner_oh = NM'(1) << r_owner;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_tmo      = (w_cnt_inc == '1);

  always_comb begin
    w_state_nx     = r_state;
    w_grant_nx     = r_grant;
    w_ptr_nx       = r_ptr;
    w_lock_hold_nx = r_lock_hold;
    w_owner_nx     = r_owner;
    w_cnt_nx       = r_cnt;
    w_ack_nx       = r_ack;
    w_load_nx      = '0;
    w_err_nx       = r_err;
    w_rdata_nx     = r_rdata;
    case (r_state)
      S_REQ: begin
        w_cnt_nx = w_cnt_inc;
        if (s_ack) begin
          if (!s_write) w_rdata_nx = s_rdata;
          w_err_nx   = '0;
          w_ack_nx   = r_grant;
          w_load_nx  = s_write ? '0 : r_grant;
          w_state_nx = S_DONE;
        end else if (w_tmo) begin
          w_rdata_nx = '0;
          w_err_nx   = r_grant;
          w_ack_nx   = r_grant;
          w_load_nx  = s_write ? '0 : r_grant;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (!(|(m_req & r_grant))) begin
          w_state_nx     = S_IDLE;
          w_ptr_nx       = w_gidx;
          w_lock_hold_nx = |(m_lock & r_grant);
          w_owner_nx     = w_gidx;
          w_grant_nx     = '0;
          w_cnt_nx       = '0;
          w_ack_nx       = '0;
          w_err_nx       = '0;
        end
      end
      default: begin
        // Idle, and the unreachable code 3 recovers here as well
        w_state_nx = S_IDLE;
        if (!m_lock[r_owner]) w_lock_hold_nx = 1'b0;
        if (r_lock_hold) begin
          if (m_req[r_owner]) begin
            w_grant_nx = w_owner_oh;
            w_state_nx = S_REQ;
          end
        end else if (w_any) begin
          w_grant_nx = w_pick;
          w_state_nx = S_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_ptr       <= PW'(NM - 1);
      r_lock_hold <= 1'b0;
      r_owner     <= PW'(MST_CPU);
      r_cnt       <= '0;
      r_ack       <= '0;
      r_load      <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_grant     <= w_grant_nx;
      r_ptr       <= w_ptr_nx;
      r_lock_hold <= w_lock_hold_nx;
      r_owner     <= w_owner_nx;
      r_cnt       <= w_cnt_nx;
      r_ack       <= w_ack_nx;
      r_load      <= w_load_nx;
      r_err       <= w_err_nx;
      r_rdata     <= w_rdata_nx;
    end
  end

  assign grant     = r_grant;
  assign m_ack     = r_ack;
  assign m_load    = r_load;
  assign m_err     = r_err;
  assign m_rdata   = r_rdata;
  assign arb_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_xbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbus_arbiter
// Description : Directed self-checking bench for xbus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbus_arbiter;

  localparam int NM = 4;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int TMO_W = 6;

  logic             mclk;
  logic             reset_n;
  logic [NM-1:0]    m_req, m_write, m_lock;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack, m_load, m_err;
  logic [DW-1:0]    m_rdata;
  logic             s_req, s_write;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW-1:0]    s_rdata;
  logic             s_ack;
  logic [NM-1:0]    grant;
  logic [1:0]       arb_state;

  int vectors;
  int miscompares;

  xbus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .m_req(m_req), .m_write(m_write), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_load(m_load), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .arb_state(arb_state)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge mclk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    m_req = '0; m_write = '0; m_lock = '0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ack = 1'b0;
    tick; tick;
    vectors++;
    if (grant !== 4'b0000 || s_req !== 1'b0 || arb_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: grant=%b s_req=%b state=%0d, want 0000/0/0", grant, s_req, arb_state);
    end
    vectors++;
    if (m_ack !== 4'b0 || m_load !== 4'b0 || m_err !== 4'b0 || m_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_resp: ack=%b load=%b err=%b rdata=%h, want zeros", m_ack, m_load, m_err, m_rdata);
    end
    vectors++;
    if (s_write !== 1'b0 || s_addr !== '0 || s_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_slave: s_write=%b s_addr=%h s_wdata=%h, want zeros", s_write, s_addr, s_wdata);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    m_addr[0*AW +: AW] = 22'o17000000;
    m_write = 4'b0000;
    m_req = 4'b0001;
    tick;
    vectors++;
    if (grant !== 4'b0001 || s_req !== 1'b1 || s_addr !== 22'o17000000 || s_write !== 1'b0) begin
      miscompares++;
      $display("FAIL read_grant: grant=%b s_req=%b s_addr=%o s_write=%b, want 0001/1/17000000/0",
               grant, s_req, s_addr, s_write);
    end
    tick; tick; tick;
    vectors++;
    if (m_ack !== 4'b0000 || s_req !== 1'b1) begin
      miscompares++;
      $display("FAIL read_wait: m_ack=%b s_req=%b, want 0000/1", m_ack, s_req);
    end
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    tick;
    s_ack = 1'b0; s_rdata = 32'h0;
    vectors++;
    if (m_ack !== 4'b0001 || m_load !== 4'b0001 || m_err !== 4'b0000 || m_rdata !== 32'hDEADBEEF
        || s_req !== 1'b0 || arb_state !== 2'd2) begin
      miscompares++;
      $display("FAIL read_done: ack=%b load=%b err=%b rdata=%h s_req=%b st=%0d, want 0001/0001/0000/deadbeef/0/2",
               m_ack, m_load, m_err, m_rdata, s_req, arb_state);
    end
    tick;
    vectors++;
    if (m_ack !== 4'b0001 || m_load !== 4'b0000) begin
      miscompares++;
      $display("FAIL read_hold: ack=%b load=%b, want 0001/0000", m_ack, m_load);
    end
    m_req = 4'b0000;
    tick;
    vectors++;
    if (m_ack !== 4'b0000 || grant !== 4'b0000 || arb_state !== 2'd0) begin
      miscompares++;
      $display("FAIL read_release: ack=%b grant=%b st=%0d, want 0000/0000/0", m_ack, grant, arb_state);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    m_write = 4'b0000;
    m_req = 4'b1111;
    s_ack = 1'b1;
    s_rdata = 32'h0000_1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      tick;
      vectors++;
      if (grant !== exp || arb_state !== 2'd1) begin
        miscompares++;
        $display("FAIL rr_grant%0d: grant=%b st=%0d, want %b/1", k, grant, arb_state, exp);
      end
      tick;
      vectors++;
      if (m_ack !== exp || m_load !== exp) begin
        miscompares++;
        $display("FAIL rr_ack%0d: ack=%b load=%b, want %b", k, m_ack, m_load, exp);
      end
      m_req = m_req & ~exp;
      tick;
      vectors++;
      if (grant !== 4'b0000 || arb_state !== 2'd0) begin
        miscompares++;
        $display("FAIL rr_idle%0d: grant=%b st=%0d, want 0000/0", k, grant, arb_state);
      end
      m_req = (k == 4) ? 4'b0000 : 4'b1111;
    end
    s_ack = 1'b0;
    tick;
  endtask

  task automatic test_lock;
    // ptr is 0 after the previous test, so the disk wins the first scan
    m_write = 4'b0010;
    m_lock = 4'b0010;
    m_req = 4'b0011;
    s_ack = 1'b1;
    s_rdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      m_addr[1*AW +: AW] = 22'(32'h100 + k);
      m_wdata[1*DW +: DW] = 32'hA000_0000 + k;
      tick;
      vectors++;
      if (grant !== 4'b0010 || s_write !== 1'b1 || s_addr !== 22'(32'h100 + k)
          || s_wdata !== 32'hA000_0000 + k) begin
        miscompares++;
        $display("FAIL lock_grant%0d: grant=%b s_write=%b s_addr=%h s_wdata=%h, want 0010/1/%h/%h",
                 k, grant, s_write, s_addr, s_wdata, 32'h100 + k, 32'hA000_0000 + k);
      end
      tick;
      vectors++;
      if (m_ack !== 4'b0010 || m_load !== 4'b0000) begin
        miscompares++;
        $display("FAIL lock_ack%0d: ack=%b load=%b, want 0010/0000", k, m_ack, m_load);
      end
      m_req[1] = 1'b0;
      tick;
      vectors++;
      if (grant !== 4'b0000) begin
        miscompares++;
        $display("FAIL lock_idle%0d: grant=%b, want 0000", k, grant);
      end
      if (k < 2) m_req[1] = 1'b1;
    end
    tick;
    vectors++;
    if (grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL lock_block: grant=%b, want 0000 (CPU blocked by lock)", grant);
    end
    m_lock = 4'b0000;
    tick;
    vectors++;
    if (grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL lock_dropidle: grant=%b, want 0000", grant);
    end
    tick;
    vectors++;
    if (grant !== 4'b0001 || s_write !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_cpu: grant=%b s_write=%b, want 0001/0", grant, s_write);
    end
    tick;
    vectors++;
    if (m_ack !== 4'b0001 || m_load !== 4'b0001 || m_rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL lock_cpu_ack: ack=%b load=%b rdata=%h, want 0001/0001/12345678", m_ack, m_load, m_rdata);
    end
    m_req = 4'b0000;
    s_ack = 1'b0;
    tick;
  endtask

  task automatic test_timeout(input bit collide);
    int n;
    m_write = 4'b0000;
    m_addr[0*AW +: AW] = 22'o17777777;
    m_req = 4'b0001;
    tick;
    n = 0;
    while (s_req === 1'b1 && n < 100) begin
      n++;
      if (collide && n == 63) begin
        s_ack = 1'b1;
        s_rdata = 32'hCAFE_F00D;
      end
      tick;
    end
    s_ack = 1'b0;
    vectors++;
    if (n != 63) begin
      miscompares++;
      $display("FAIL tmo_len%0d: s_req high %0d cycles, want 63", collide, n);
    end
    vectors++;
    if (collide) begin
      if (m_ack !== 4'b0001 || m_err !== 4'b0000 || m_load !== 4'b0001 || m_rdata !== 32'hCAFE_F00D) begin
        miscompares++;
        $display("FAIL collide_done: ack=%b err=%b load=%b rdata=%h, want 0001/0000/0001/cafef00d",
                 m_ack, m_err, m_load, m_rdata);
      end
    end else begin
      if (m_ack !== 4'b0001 || m_err !== 4'b0001 || m_load !== 4'b0001 || m_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL tmo_done: ack=%b err=%b load=%b rdata=%h, want 0001/0001/0001/0",
                 m_ack, m_err, m_load, m_rdata);
      end
    end
    m_req = 4'b0000;
    tick;
    vectors++;
    if (m_ack !== 4'b0000 || m_err !== 4'b0000) begin
      miscompares++;
      $display("FAIL tmo_clear%0d: ack=%b err=%b, want 0000/0000", collide, m_ack, m_err);
    end
  endtask

  task automatic test_drop_midreq;
    m_write = 4'b0001;
    m_wdata[0*DW +: DW] = 32'h5555_AAAA;
    m_req = 4'b0001;
    tick;
    m_req = 4'b0000;
    tick;
    s_ack = 1'b1;
    tick;
    s_ack = 1'b0;
    vectors++;
    if (m_ack !== 4'b0001 || m_load !== 4'b0000 || arb_state !== 2'd2) begin
      miscompares++;
      $display("FAIL drop_done: ack=%b load=%b st=%0d, want 0001/0000/2", m_ack, m_load, arb_state);
    end
    tick;
    vectors++;
    if (m_ack !== 4'b0000 || arb_state !== 2'd0) begin
      miscompares++;
      $display("FAIL drop_oneshot: ack=%b st=%0d, want 0000/0", m_ack, arb_state);
    end
  endtask

  task automatic test_reset_mid_req;
    m_write = 4'b0000;
    m_req = 4'b0010;
    tick;
    tick;
    vectors++;
    if (s_req !== 1'b1 || grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL rst_pre: s_req=%b grant=%b, want 1/0010", s_req, grant);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (s_req !== 1'b0 || grant !== 4'b0000 || m_ack !== 4'b0000 || arb_state !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_async: s_req=%b grant=%b ack=%b st=%0d, want 0/0000/0000/0",
               s_req, grant, m_ack, arb_state);
    end
    m_req = 4'b1111;
    tick;
    reset_n = 1'b1;
    tick;
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_first: grant=%b, want 0001", grant);
    end
    m_req = 4'b0000;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_single_read;
    test_round_robin;
    test_lock;
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_drop_midreq;
    test_reset_mid_req;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
